// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-timer sequencer: keypad entry of an MM:SS BCD time,
// 1 Hz countdown with magnetron enable, pause/resume and completion.
module microwave_timer_ctrl #(
    parameter int TICK_DIV = 100
) (
    input  logic       CLK_100HZ,
    input  logic       RST_N,
    input  logic [9:0] KPAD,
    input  logic       START,
    input  logic       STOP,
    input  logic       DOOR_CLOSED,
    output logic [3:0] MIN_T,
    output logic [3:0] MIN_U,
    output logic [3:0] SEC_T,
    output logic [3:0] SEC_U,
    output logic       MAG_ON,
    output logic       SEC_TICK,
    output logic       DONE,
    output logic [2:0] STATE
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENTRY  = 3'd1,
        S_COOK   = 3'd2,
        S_PAUSED = 3'd3,
        S_FIN    = 3'd4
    } state_t;

    state_t        r_state;
    logic [3:0]    r_mt, r_mu, r_st, r_su;
    logic [PW-1:0] r_presc;
    logic          r_mag, r_tick, r_done;
    logic [9:0]    r_kpad_q;
    logic          r_start_q, r_stop_q;

    logic       w_onehot, w_key_ev, w_start_ev, w_stop_ev, w_can_start;
    logic [3:0] w_key_val;
    logic [3:0] w_dmt, w_dmu, w_dst, w_dsu;
    logic       w_b0, w_b1, w_b2, w_dec_zero;

    // A key only counts when exactly one digit is pressed from an all-released keypad
    assign w_onehot   = (KPAD != 10'd0) && ((KPAD & (KPAD - 10'd1)) == 10'd0);
    assign w_key_ev   = w_onehot && (r_kpad_q == 10'd0);
    assign w_start_ev = START & ~r_start_q;
    assign w_stop_ev  = STOP & ~r_stop_q;

    // Start needs a closed door, a non-zero time and a valid seconds-tens digit
    assign w_can_start = DOOR_CLOSED &&
                         ({r_mt, r_mu, r_st, r_su} != 16'h0000) &&
                         (r_st <= 4'd5);

    // One-hot keypad to BCD digit
    always_comb begin
        w_key_val = 4'd0;
        for (int i = 0; i < 10; i++)
            if (KPAD[i]) w_key_val = 4'(i);
    end

    // BCD borrow chain for the one-second decrement (seconds tens wrap to 5)
    always_comb begin
        w_b0  = (r_su == 4'd0);
        w_dsu = w_b0 ? 4'd9 : r_su - 4'd1;
        w_b1  = w_b0 && (r_st == 4'd0);
        w_dst = w_b0 ? ((r_st == 4'd0) ? 4'd5 : r_st - 4'd1) : r_st;
        w_b2  = w_b1 && (r_mu == 4'd0);
        w_dmu = w_b1 ? ((r_mu == 4'd0) ? 4'd9 : r_mu - 4'd1) : r_mu;
        w_dmt = w_b2 ? r_mt - 4'd1 : r_mt;
        w_dec_zero = ({w_dmt, w_dmu, w_dst, w_dsu} == 16'h0000);
    end

    // Main sequencer: state, digits, prescaler and registered outputs
    always_ff @(posedge CLK_100HZ) begin
        if (!RST_N) begin
            r_state   <= S_IDLE;
            r_mt      <= 4'd0;
            r_mu      <= 4'd0;
            r_st      <= 4'd0;
            r_su      <= 4'd0;
            r_presc   <= '0;
            r_mag     <= 1'b0;
            r_tick    <= 1'b0;
            r_done    <= 1'b0;
            r_kpad_q  <= 10'd0;
            r_start_q <= 1'b0;
            r_stop_q  <= 1'b0;
        end else begin
            r_kpad_q  <= KPAD;
            r_start_q <= START;
            r_stop_q  <= STOP;
            r_tick    <= 1'b0;
            case (r_state)
                S_IDLE, S_ENTRY: begin
                    if (w_stop_ev) begin
                        r_state <= S_IDLE;
                        r_mt <= 4'd0; r_mu <= 4'd0; r_st <= 4'd0; r_su <= 4'd0;
                    end else if (w_start_ev) begin
                        if (w_can_start) begin
                            r_state <= S_COOK;
                            r_mag   <= 1'b1;
                            r_presc <= '0;
                        end
                    end else if (w_key_ev) begin
                        r_state <= S_ENTRY;
                        r_mt <= r_mu; r_mu <= r_st; r_st <= r_su; r_su <= w_key_val;
                    end
                end
                S_COOK: begin
                    // Door or STOP freezes the partial second so resume continues it
                    if (!DOOR_CLOSED || w_stop_ev) begin
                        r_state <= S_PAUSED;
                        r_mag   <= 1'b0;
                    end else if (r_presc == PRESC_MAX) begin
                        r_presc <= '0;
                        r_tick  <= 1'b1;
                        r_mt <= w_dmt; r_mu <= w_dmu; r_st <= w_dst; r_su <= w_dsu;
                        if (w_dec_zero) begin
                            r_state <= S_FIN;
                            r_mag   <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                S_PAUSED: begin
                    if (w_stop_ev) begin
                        r_state <= S_IDLE;
                        r_presc <= '0;
                        r_mt <= 4'd0; r_mu <= 4'd0; r_st <= 4'd0; r_su <= 4'd0;
                    end else if (w_start_ev && DOOR_CLOSED) begin
                        r_state <= S_COOK;
                        r_mag   <= 1'b1;
                    end
                end
                S_FIN: begin
                    // Any user activity acknowledges completion; the event is consumed
                    if (w_key_ev || w_start_ev || w_stop_ev || !DOOR_CLOSED) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_mag   <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign MIN_T    = r_mt;
    assign MIN_U    = r_mu;
    assign SEC_T    = r_st;
    assign SEC_U    = r_su;
    assign MAG_ON   = r_mag;
    assign SEC_TICK = r_tick;
    assign DONE     = r_done;
    assign STATE    = r_state;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed bench for microwave_timer_ctrl with TICK_DIV=4.
module tb_microwave_timer_ctrl;

    logic       clk;
    logic       rst_n;
    logic [9:0] kpad;
    logic       start, stop, door;
    logic [3:0] min_t, min_u, sec_t, sec_u;
    logic       mag_on, sec_tick, done;
    logic [2:0] state;
    logic [15:0] tm;

    int n_vec = 0;
    int n_err = 0;

    microwave_timer_ctrl #(.TICK_DIV(4)) dut (
        .CLK_100HZ(clk), .RST_N(rst_n), .KPAD(kpad), .START(start), .STOP(stop),
        .DOOR_CLOSED(door), .MIN_T(min_t), .MIN_U(min_u), .SEC_T(sec_t), .SEC_U(sec_u),
        .MAG_ON(mag_on), .SEC_TICK(sec_tick), .DONE(done), .STATE(state)
    );

    assign tm = {min_t, min_u, sec_t, sec_u};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input int k);
        kpad = 10'd1 << k;
        tick();
        kpad = 10'd0;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0; tick();
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0; tick();
    endtask

    initial begin
        rst_n = 1'b0; kpad = 10'd0; start = 1'b0; stop = 1'b0; door = 1'b1;
        ticks(2);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_time", 32'(tm), 32'h0000);
        chk("rst_mag", 32'(mag_on), 32'd0);
        chk("rst_tick", 32'(sec_tick), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();

        // Digit entry
        press(1); press(3); press(0);
        chk("entry_130", 32'(tm), 32'h0130);
        chk("entry_state", 32'(state), 32'd1);
        pulse_stop();
        chk("stop_clear", 32'(tm), 32'h0000);
        chk("stop_idle", 32'(state), 32'd0);
        press(1); press(2); press(3); press(4); press(7);
        chk("entry_2347", 32'(tm), 32'h2347);
        pulse_stop();

        // Multi-hot and held key
        kpad = 10'b0100000010; tick(); kpad = 10'd0; tick();
        chk("multihot_time", 32'(tm), 32'h0000);
        chk("multihot_state", 32'(state), 32'd0);
        kpad = 10'b0000010000; ticks(50); kpad = 10'd0; tick();
        chk("held_time", 32'(tm), 32'h0004);
        chk("held_state", 32'(state), 32'd1);
        pulse_stop();

        // Rejected starts
        pulse_start();
        chk("start_zero_state", 32'(state), 32'd0);
        chk("start_zero_mag", 32'(mag_on), 32'd0);
        press(0); press(0); press(7); press(5);
        pulse_start();
        chk("start_75_state", 32'(state), 32'd1);
        chk("start_75_time", 32'(tm), 32'h0075);
        chk("start_75_mag", 32'(mag_on), 32'd0);
        pulse_stop();
        press(1); press(2);
        door = 1'b0;
        pulse_start();
        chk("start_door_state", 32'(state), 32'd1);
        chk("start_door_mag", 32'(mag_on), 32'd0);
        door = 1'b1;
        pulse_stop();

        // Full cook of 1:00
        press(1); press(0); press(0);
        start = 1'b1; tick(); start = 1'b0;
        chk("cook_state", 32'(state), 32'd2);
        chk("cook_mag", 32'(mag_on), 32'd1);
        ticks(3);
        chk("cook_pre_tick", 32'(sec_tick), 32'd0);
        tick();
        chk("cook_tick1", 32'(sec_tick), 32'd1);
        chk("cook_059", 32'(tm), 32'h0059);
        tick();
        chk("cook_tick_pulse", 32'(sec_tick), 32'd0);
        ticks(234);
        chk("cook_001", 32'(tm), 32'h0001);
        chk("cook_001_state", 32'(state), 32'd2);
        tick();
        chk("fin_state", 32'(state), 32'd4);
        chk("fin_done", 32'(done), 32'd1);
        chk("fin_mag", 32'(mag_on), 32'd0);
        chk("fin_time", 32'(tm), 32'h0000);
        start = 1'b1; tick(); start = 1'b0;
        chk("fin_exit_state", 32'(state), 32'd0);
        chk("fin_exit_done", 32'(done), 32'd0);
        tick();

        // Pause on door, resume partial second
        press(1); press(2);
        start = 1'b1; tick(); start = 1'b0;
        ticks(4);
        chk("pause_011", 32'(tm), 32'h0011);
        ticks(2);
        door = 1'b0; tick();
        chk("pause_state", 32'(state), 32'd3);
        chk("pause_mag", 32'(mag_on), 32'd0);
        chk("pause_time", 32'(tm), 32'h0011);
        pulse_start();
        chk("pause_door_start", 32'(state), 32'd3);
        door = 1'b1; tick();
        start = 1'b1; tick(); start = 1'b0;
        chk("resume_state", 32'(state), 32'd2);
        chk("resume_mag", 32'(mag_on), 32'd1);
        tick();
        chk("resume_no_tick", 32'(sec_tick), 32'd0);
        tick();
        chk("resume_tick", 32'(sec_tick), 32'd1);
        chk("resume_010", 32'(tm), 32'h0010);

        // STOP twice: pause then cancel
        stop = 1'b1; tick(); stop = 1'b0;
        chk("stop1_state", 32'(state), 32'd3);
        chk("stop1_time", 32'(tm), 32'h0010);
        tick();
        stop = 1'b1; tick(); stop = 1'b0;
        chk("stop2_state", 32'(state), 32'd0);
        chk("stop2_time", 32'(tm), 32'h0000);
        tick();

        // Reset mid-cook
        press(5);
        start = 1'b1; tick(); start = 1'b0;
        chk("rcook_state", 32'(state), 32'd2);
        tick();
        rst_n = 1'b0; tick();
        chk("rcook_rst_state", 32'(state), 32'd0);
        chk("rcook_rst_time", 32'(tm), 32'h0000);
        chk("rcook_rst_mag", 32'(mag_on), 32'd0);
        rst_n = 1'b1; tick();

        // Door opens on the final tick: door wins
        press(1);
        start = 1'b1; tick(); start = 1'b0;
        ticks(3);
        door = 1'b0; tick();
        chk("lastdoor_state", 32'(state), 32'd3);
        chk("lastdoor_time", 32'(tm), 32'h0001);
        chk("lastdoor_tick", 32'(sec_tick), 32'd0);
        chk("lastdoor_done", 32'(done), 32'd0);
        door = 1'b1;
        pulse_stop();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
